config_loader: RTL and testbench
================================

Name: config_loader

Overview:
- Sequences the configuration of the fabric's logic elements: accepts bitstream words from a host over a valid/ready stream and serialises them into the fabric configuration shift chain.
- Each logic element consumes 65 config bits: 64 LUT bits, then 1 comb/seq select bit.
- Holds the fabric's active-low `nreset` asserted until the full CONFIG_BITS have been shifted, then releases it.
- Sits between the host/bitstream interface and the top-level config chain input.

Parameters:
- WORD_WIDTH, 32: host word width in bits.
- CHAIN_WIDTH, 1: bits shifted into the chain per cycle. Must divide WORD_WIDTH.
- CONFIG_BITS, 4160: total chain length (64 LEs x 65). Must be a multiple of CHAIN_WIDTH; elaboration fails otherwise.

Ports:
- clock, input, 1: sole clock; everything is rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: pulse; begin a configuration load.
- abort, input, 1: pulse; abandon the load and return to IDLE.
- in_valid, input, 1: host word valid.
- in_data, input, WORD_WIDTH: host word, LSB shifted first.
- in_ready, output, 1: loader can accept a word.
- cfg_shift_en, output, 1: chain shift strobe.
- cfg_data, output, CHAIN_WIDTH: chain data, valid when cfg_shift_en=1.
- fabric_nreset, output, 1: active-low reset to the fabric LEs.
- busy, output, 1: state is WAIT or SHIFT.
- done, output, 1: full chain loaded.
- error, output, 1: sticky protocol error.

Behaviour:
- Reset values: all outputs 0, so fabric_nreset=0 (fabric held in reset). State=IDLE, bit counter=0, word shift register=0.
- All outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> clear bit counter and error, go to WAIT.
- WAIT:
  - in_ready=1.
  - in_valid & in_ready -> capture in_data into the shift register, clear the beat counter, go to SHIFT.
- SHIFT:
  - in_ready=0 (no prefetch).
  - Each cycle: cfg_shift_en=1, cfg_data=sreg[CHAIN_WIDTH-1:0]; sreg shifts right by CHAIN_WIDTH; bit counter += CHAIN_WIDTH.
  - Bit counter reaches CONFIG_BITS -> go to DONE immediately. Remaining bits of the current word are discarded.
  - Otherwise, after WORD_WIDTH/CHAIN_WIDTH beats -> go to WAIT.
- DONE:
  - done=1; fabric_nreset=1 from the first DONE cycle.
  - cfg_shift_en=0; in_ready=0.
  - start=1 -> go to WAIT; done and fabric_nreset drop to 0 on the next cycle (reconfiguration).
- Latency and throughput:
  - First cfg_shift_en occurs in the cycle after the word handshake.
  - One word per WORD_WIDTH/CHAIN_WIDTH+1 cycles.
- Width rules:
  - Bit counter width is clog2(CONFIG_BITS+1).
  - Beat counter width is clog2(WORD_WIDTH/CHAIN_WIDTH).
  - No wrap: the counter never exceeds CONFIG_BITS.
- Simultaneous events:
  - abort has priority over start and over the handshake. In any state, abort -> IDLE with done=0, fabric_nreset=0, counters cleared; error is unchanged.
  - start in WAIT or SHIFT is ignored and sets error=1 (sticky). error clears only on an accepted start from IDLE or DONE.
  - in_valid in IDLE, SHIFT or DONE is not a handshake (in_ready=0); the host must hold the word.
- Reset mid-operation forces the reset values asynchronously, including fabric_nreset=0. No partial configuration is ever released.

Decomposition:
- Shared package kfpga_cfg_pkg:
  - state enum {IDLE, WAIT, SHIFT, DONE}.
  - LE_CONFIG_BITS=65, LUT_CONFIG_BITS=64.
  - Helper localparams: BEATS_PER_WORD, counter widths.
- One natural sub-module, cfg_serializer: word load plus shift-right register with beat counter, exposing load, shift, data_out and last_beat.
- FSM and bit counter live in config_loader.

Test Plan:
- Basic load, with CONFIG_BITS=65, CHAIN_WIDTH=1:
  - Stimulus: start, then words 0xDEADBEEF, 0x12345678, 0x00000001.
  - Required: exactly 65 cfg_shift_en pulses; cfg_data sequence is the words' bits LSB-first; final bit =1.
  - Required: done=1 and fabric_nreset=1 in the first DONE cycle; in_ready never asserted after the third handshake.
- Backpressure: host delays in_valid 5 cycles before each word -> no cfg_shift_en while in WAIT; shifted bit sequence identical to the basic load.
- Abort mid-SHIFT, after 40 bits:
  - Required: next cycle state=IDLE, cfg_shift_en=0, done=0, fabric_nreset=0.
  - Required: a new start followed by three words yields 65 fresh shifts.
- start while busy: pulse start during SHIFT -> error=1, shifting unaffected; error stays 1 through DONE and clears on the next start from DONE.
- Async reset: assert reset between clock edges during SHIFT -> all outputs 0 immediately, without a clock edge; after release, IDLE with in_ready=0.
- Wide chain, with CHAIN_WIDTH=4, CONFIG_BITS=64, WORD_WIDTH=32:
  - Required: 8 beats per word, 16 beats total.
  - Required: cfg_data on beat 0 equals in_data[3:0]; DONE follows the 16th beat.

Source files
------------

// File: rtl/kfpga_cfg_pkg.sv
// Shared types and sizing helpers for the fabric configuration loader.
package kfpga_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cfg_state_t;

  localparam int LUT_CONFIG_BITS = 64;
  localparam int LE_CONFIG_BITS  = LUT_CONFIG_BITS + 1;

  localparam int DEFAULT_NUM_LES     = 64;
  localparam int DEFAULT_WORD_WIDTH  = 32;
  localparam int DEFAULT_CHAIN_WIDTH = 1;
  localparam int DEFAULT_CONFIG_BITS = DEFAULT_NUM_LES * LE_CONFIG_BITS;

  // Chain beats needed to drain one host word.
  function automatic int beats_per_word(input int word_width, input int chain_width);
    return word_width / chain_width;
  endfunction

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int BEATS_PER_WORD = beats_per_word(DEFAULT_WORD_WIDTH, DEFAULT_CHAIN_WIDTH);
  localparam int BEAT_CNT_W     = cnt_width(BEATS_PER_WORD);
  localparam int BIT_CNT_W      = $clog2(DEFAULT_CONFIG_BITS + 1);

endpackage

// File: rtl/cfg_serializer.sv
// Word-to-chain serializer: loads one host word and shifts it out LSB first,
// CHAIN_WIDTH bits per beat, flagging the final beat of the word.
module cfg_serializer
  import kfpga_cfg_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int CHAIN_WIDTH = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   shift,
  input  logic [WORD_WIDTH-1:0]  word_in,
  output logic [CHAIN_WIDTH-1:0] data_out,
  output logic                   last_beat
);

  localparam int BEATS  = beats_per_word(WORD_WIDTH, CHAIN_WIDTH);
  localparam int BEAT_W = cnt_width(BEATS);

  logic [WORD_WIDTH-1:0] sreg;
  logic [BEAT_W-1:0]     beat_cnt;

  // Clear beats load, load beats shift; shifting moves the next beats into the low bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg     <= '0;
      beat_cnt <= '0;
    end else if (clear) begin
      sreg     <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      sreg     <= word_in;
      beat_cnt <= '0;
    end else if (shift) begin
      sreg     <= sreg >> CHAIN_WIDTH;
      beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  assign data_out  = sreg[CHAIN_WIDTH-1:0];
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/config_loader.sv
// Fabric configuration loader: takes bitstream words from the host and feeds
// the config shift chain, keeping the fabric in reset until the chain is full.
module config_loader
  import kfpga_cfg_pkg::*;
#(
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int CHAIN_WIDTH = DEFAULT_CHAIN_WIDTH,
  parameter int CONFIG_BITS = DEFAULT_CONFIG_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [WORD_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   cfg_shift_en,
  output logic [CHAIN_WIDTH-1:0] cfg_data,
  output logic                   fabric_nreset,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int BIT_W = $clog2(CONFIG_BITS + 1);

  generate
    if ((WORD_WIDTH % CHAIN_WIDTH) != 0) begin : g_bad_word_width
      $error("config_loader: CHAIN_WIDTH must divide WORD_WIDTH");
    end
    if ((CONFIG_BITS % CHAIN_WIDTH) != 0) begin : g_bad_config_bits
      $error("config_loader: CONFIG_BITS must be a multiple of CHAIN_WIDTH");
    end
  endgenerate

  cfg_state_t             state;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   last_bit;
  logic                   last_beat;
  logic                   ser_load;
  logic                   ser_shift;
  logic [CHAIN_WIDTH-1:0] ser_data;

  // The beat being shifted now is the last one the chain needs.
  assign last_bit  = (bit_cnt == BIT_W'(CONFIG_BITS - CHAIN_WIDTH));
  assign ser_load  = (state == WAIT) && in_valid;
  assign ser_shift = (state == SHIFT);

  cfg_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .CHAIN_WIDTH(CHAIN_WIDTH)
  ) u_serializer (
    .clock    (clock),
    .reset    (reset),
    .clear    (abort),
    .load     (ser_load),
    .shift    (ser_shift),
    .word_in  (in_data),
    .data_out (ser_data),
    .last_beat(last_beat)
  );

  // Load sequencer: abort wins over everything, start while busy only flags an error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      error   <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bit_cnt <= '0;
            error   <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (start) error <= 1'b1;
          if (in_valid) state <= SHIFT;
        end
        SHIFT: begin
          if (start) error <= 1'b1;
          bit_cnt <= bit_cnt + BIT_W'(CHAIN_WIDTH);
          if (last_bit) state <= DONE;
          else if (last_beat) state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state == WAIT);
  assign busy          = (state == WAIT) || (state == SHIFT);
  assign cfg_shift_en  = (state == SHIFT);
  assign cfg_data      = (state == SHIFT) ? ser_data : '0;
  assign done          = (state == DONE);
  assign fabric_nreset = (state == DONE);

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 65-bit single-wire chain and a 64-bit nibble-wide chain.
module tb_config_loader;

  typedef struct {
    string             name;
    logic [2:0][31:0]  words;
    int                gap;
    bit                poke_start;
    logic              exp_last;
    logic              exp_error;
    int                exp_shifts;
  } vec_t;

  logic        clock;
  logic        reset;

  logic        a_start, a_abort, a_in_valid;
  logic [31:0] a_in_data;
  logic        a_in_ready, a_cfg_shift_en, a_fabric_nreset, a_busy, a_done, a_error;
  logic [0:0]  a_cfg_data;

  logic        b_start, b_abort, b_in_valid;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_cfg_shift_en, b_fabric_nreset, b_busy, b_done, b_error;
  logic [3:0]  b_cfg_data;

  int compared;
  int mismatched;

  config_loader #(.WORD_WIDTH(32), .CHAIN_WIDTH(1), .CONFIG_BITS(65)) dut_a (
    .clock(clock), .reset(reset), .start(a_start), .abort(a_abort),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .cfg_shift_en(a_cfg_shift_en), .cfg_data(a_cfg_data),
    .fabric_nreset(a_fabric_nreset), .busy(a_busy), .done(a_done), .error(a_error)
  );

  config_loader #(.WORD_WIDTH(32), .CHAIN_WIDTH(4), .CONFIG_BITS(64)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .abort(b_abort),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .cfg_shift_en(b_cfg_shift_en), .cfg_data(b_cfg_data),
    .fabric_nreset(b_fabric_nreset), .busy(b_busy), .done(b_done), .error(b_error)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case a sequence gets stuck somewhere unexpected.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Run one full load on the single-wire chain and check the shifted stream.
  task automatic apply_stimulus(input vec_t v);
    logic [127:0] cap;
    logic [127:0] exp_bits;
    logic [95:0]  flat;
    int           n;
    int           t;
    int           gap_bad;
    bit           ready_late;
    cap = '0; n = 0; gap_bad = 0; ready_late = 1'b0;
    flat = v.words;
    exp_bits = '0;
    for (int i = 0; i < v.exp_shifts; i++) exp_bits[i] = flat[i];

    @(negedge clock); a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    check_output({v.name, " error after start"}, a_error, 0);
    check_output({v.name, " busy after start"}, a_busy, 1);

    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < v.gap; g++) begin
        if (a_cfg_shift_en || !a_in_ready) gap_bad++;
        @(negedge clock);
      end
      t = 0;
      while (!a_in_ready && t < 100) begin @(negedge clock); t++; end
      check_output({v.name, " ready timeout"}, a_in_ready, 1);
      a_in_valid = 1'b1;
      a_in_data  = v.words[k];
      @(negedge clock);
      a_in_valid = 1'b0;
      a_in_data  = '0;
      t = 0;
      while (a_cfg_shift_en && t < 100) begin
        if (n < 128) cap[n] = a_cfg_data[0];
        n++;
        if (k == 2 && a_in_ready) ready_late = 1'b1;
        a_start = (v.poke_start && k == 0 && t == 3);
        @(negedge clock);
        t++;
      end
      a_start = 1'b0;
    end
    if (a_in_ready) ready_late = 1'b1;

    check_output({v.name, " no shift while waiting"}, gap_bad, 0);
    check_output({v.name, " done in first DONE cycle"}, a_done, 1);
    check_output({v.name, " fabric_nreset released"}, a_fabric_nreset, 1);
    check_output({v.name, " busy cleared"}, a_busy, 0);
    check_output({v.name, " in_ready after last word"}, ready_late, 0);
    check_output({v.name, " shift count"}, n, v.exp_shifts);
    check_output({v.name, " shifted bits"}, cap, exp_bits);
    check_output({v.name, " final bit"}, cap[v.exp_shifts-1], v.exp_last);
    check_output({v.name, " error flag"}, a_error, v.exp_error);
  endtask

  // Abort after exactly 40 bits have been strobed into the chain.
  task automatic abort_sequence();
    logic [63:0] cap;
    logic [63:0] words;
    int          n;
    int          t;
    cap = '0; n = 0;
    words = {32'h0BADF00D, 32'hC001D00D};
    @(negedge clock); a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t = 0;
      while (!a_in_ready && t < 100) begin @(negedge clock); t++; end
      check_output("abort ready timeout", a_in_ready, 1);
      a_in_valid = 1'b1;
      a_in_data  = words[k*32 +: 32];
      @(negedge clock);
      a_in_valid = 1'b0;
      t = 0;
      while (a_cfg_shift_en && t < ((k == 0) ? 100 : 7)) begin
        cap[n] = a_cfg_data[0];
        n++;
        @(negedge clock);
        t++;
      end
    end
    cap[n] = a_cfg_data[0];
    n++;
    a_abort = 1'b1;
    @(negedge clock);
    a_abort = 1'b0;
    check_output("abort shift_en", a_cfg_shift_en, 0);
    check_output("abort done", a_done, 0);
    check_output("abort fabric_nreset", a_fabric_nreset, 0);
    check_output("abort busy (IDLE)", a_busy, 0);
    check_output("abort in_ready (IDLE)", a_in_ready, 0);
    check_output("abort bits before abort", n, 40);
    check_output("abort partial stream", cap[39:0], words[39:0]);
  endtask

  // Asynchronous reset landing between clock edges in the middle of a word.
  task automatic reset_sequence();
    int t;
    @(negedge clock); a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    t = 0;
    while (!a_in_ready && t < 100) begin @(negedge clock); t++; end
    a_in_valid = 1'b1;
    a_in_data  = 32'hFFFFFFFF;
    @(negedge clock);
    a_in_valid = 1'b0;
    a_start    = 1'b1;
    @(negedge clock);
    a_start    = 1'b0;
    repeat (4) @(negedge clock);
    check_output("pre-reset error set by start in SHIFT", a_error, 1);
    check_output("pre-reset shifting", a_cfg_shift_en, 1);
    #2 reset = 1'b1;
    #1;
    check_output("async reset outputs", {a_in_ready, a_cfg_shift_en, a_cfg_data,
                 a_fabric_nreset, a_busy, a_done, a_error}, 7'b0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    check_output("post-reset in_ready", a_in_ready, 0);
    check_output("post-reset busy", a_busy, 0);
  endtask

  // Nibble-wide chain: 8 beats per word, 16 beats total, DONE right after the last.
  task automatic wide_sequence();
    logic [63:0] cap;
    logic [63:0] words;
    int          n;
    int          t;
    int          beats;
    cap = '0; n = 0;
    words = {32'hCAFEBABE, 32'h87654321};
    @(negedge clock); b_start = 1'b1;
    @(negedge clock); b_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t = 0;
      while (!b_in_ready && t < 100) begin @(negedge clock); t++; end
      check_output("wide ready timeout", b_in_ready, 1);
      b_in_valid = 1'b1;
      b_in_data  = words[k*32 +: 32];
      @(negedge clock);
      b_in_valid = 1'b0;
      if (k == 0) check_output("wide beat0 data", b_cfg_data, 4'h1);
      beats = 0;
      while (b_cfg_shift_en && beats < 20) begin
        if (n < 16) cap[n*4 +: 4] = b_cfg_data;
        n++;
        beats++;
        @(negedge clock);
      end
      check_output("wide beats per word", beats, 8);
    end
    check_output("wide total beats", n, 16);
    check_output("wide stream", cap, words);
    check_output("wide done after beat 16", b_done, 1);
    check_output("wide fabric_nreset", b_fabric_nreset, 1);
  endtask

  initial begin
    vec_t vecs [4];
    vecs[0] = '{"basic",        {32'h00000001, 32'h12345678, 32'hDEADBEEF}, 0, 1'b0, 1'b1, 1'b0, 65};
    vecs[1] = '{"backpressure", {32'h00000001, 32'h12345678, 32'hDEADBEEF}, 5, 1'b0, 1'b1, 1'b0, 65};
    vecs[2] = '{"start busy",   {32'hFFFFFFFE, 32'h0F0F0F0F, 32'hAAAA5555}, 0, 1'b1, 1'b0, 1'b1, 65};
    vecs[3] = '{"mixed",        {32'h00000003, 32'hFFFFFFFF, 32'h00000000}, 2, 1'b0, 1'b1, 1'b0, 65};

    compared = 0; mismatched = 0;
    reset = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
    b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
    #2;
    check_output("reset outputs A", {a_in_ready, a_cfg_shift_en, a_cfg_data,
                 a_fabric_nreset, a_busy, a_done, a_error}, 7'b0);
    check_output("reset outputs B", {b_in_ready, b_cfg_shift_en, b_cfg_data,
                 b_fabric_nreset, b_busy, b_done, b_error}, 10'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_output("idle in_ready", a_in_ready, 0);

    for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

    @(negedge clock);
    check_output("DONE holds fabric_nreset", a_fabric_nreset, 1);
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    check_output("restart drops done", a_done, 0);
    check_output("restart drops fabric_nreset", a_fabric_nreset, 0);
    a_abort = 1'b1;
    @(negedge clock);
    a_abort = 1'b0;

    abort_sequence();
    apply_stimulus(vecs[0]);

    reset_sequence();
    apply_stimulus(vecs[3]);

    wide_sequence();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
